jpeg_stuff_packer: RTL and testbench

//  Parametrised entropy-stage output packer; successor to the fixed 16-bit jpeg_pipeline output stage.

---
 rtl/jpeg_stuff_packer.sv | 146 ++++++++++++++
 tb/tb_jpeg_stuff_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_stuff_packer.sv
// Entropy-stage output packer: MSB-first bit packing of variable-length codes into bytes,
// JPEG 0xFF/0x00 byte stuffing, 1-padding on flush, OUT_BYTES-wide output words.
module jpeg_stuff_packer #(
  parameter int CODE_W    = 27,
  parameter int OUT_BYTES = 2,
  parameter int SIZE_W    = $clog2(CODE_W + 1),
  parameter int ACC_W     = CODE_W + 8 * OUT_BYTES + 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CODE_W-1:0]              in_code,
  input  logic [SIZE_W-1:0]              in_size,
  input  logic                           ena_in,
  input  logic                           flush,
  output logic                           rdy_out,
  output logic [8*OUT_BYTES-1:0]         out_bits,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_valid,
  output logic                           ena_out,
  input  logic                           rdy_in,
  output logic                           done_flush
);

  localparam int OUT_W = 8 * OUT_BYTES;
  localparam int VAL_W = $clog2(OUT_BYTES + 1);
  // Spare byte so padding a completely full accumulator never overflows.
  localparam int BUF_W = ACC_W + 8;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(ACC_W - CODE_W);

  typedef enum logic [1:0] {RUN, PAD, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] acc_q, acc_d;   // valid bits MSB-aligned, bits below cnt_q kept zero
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pz_q, pz_d;
  logic             live_q;

  logic [OUT_W-1:0] x_word;
  logic             x_pz;
  int               x_n;
  int               x_nb;
  logic             load;
  logic             take;
  logic             code_fire;
  logic             flush_fire;

  assign load       = !ena_out || rdy_in;
  assign rdy_out    = live_q && (state_q == RUN) && (cnt_q <= RDY_LIMIT);
  assign code_fire  = ena_in && rdy_out;
  assign flush_fire = flush && rdy_out;
  assign done_flush = (state_q == DONE);

  // Stage p0 -> p1: fill output slots from the accumulator top, owed 0x00 first
  always_comb begin
    int         avail;
    int         nb;
    logic [7:0] byte_v;
    x_word = '0;
    x_pz   = pz_q;
    x_n    = 0;
    nb     = 0;
    byte_v = '0;
    avail  = int'(cnt_q >> 3);
    for (int s = 0; s < OUT_BYTES; s++) begin
      if (x_pz) begin
        x_pz = 1'b0;
        x_n  = x_n + 1;
      end else if (nb < avail) begin
        byte_v = 8'(acc_q >> (BUF_W - 8 - 8 * nb));
        x_word[OUT_W-1-8*s -: 8] = byte_v;
        x_pz = (byte_v == 8'hFF);
        x_n  = x_n + 1;
        nb   = nb + 1;
      end
    end
    x_nb = nb;
  end

  always_comb begin
    take = 1'b0;
    if (load) begin
      if (state_q == RUN)        take = (x_n == OUT_BYTES);
      else if (state_q == DRAIN) take = (x_n != 0);
    end
  end

  always_comb begin
    logic [CODE_W-1:0] size_mask;
    logic [BUF_W-1:0]  code_top;
    logic [CNT_W-1:0]  cnt_pad;
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pz_d      = pz_q;
    size_mask = ~({CODE_W{1'b1}} << in_size);
    code_top  = {in_code & size_mask, {(BUF_W-CODE_W){1'b0}}} << (CODE_W - int'(in_size));
    cnt_pad   = (cnt_q + CNT_W'(7)) & ~CNT_W'(7);
    if (take) begin
      acc_d = acc_q << (8 * x_nb);
      cnt_d = cnt_q - CNT_W'(8 * x_nb);
      pz_d  = x_pz;
    end
    // New code lands directly below whatever survives this cycle's extraction.
    if (code_fire) begin
      acc_d = acc_d | (code_top >> cnt_d);
      cnt_d = cnt_d + CNT_W'(in_size);
    end
    case (state_q)
      RUN:   if (flush_fire) state_d = PAD;
      PAD: begin
        acc_d   = acc_q | (({BUF_W{1'b1}} >> cnt_q) & ~({BUF_W{1'b1}} >> cnt_pad));
        cnt_d   = cnt_pad;
        state_d = DRAIN;
      end
      DRAIN: if (load && (x_n == 0)) state_d = DONE;
      DONE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Stage p1: accumulator state and output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      acc_q     <= '0;
      cnt_q     <= '0;
      pz_q      <= 1'b0;
      live_q    <= 1'b0;
      out_bits  <= '0;
      out_valid <= '0;
      ena_out   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pz_q    <= pz_d;
      live_q  <= 1'b1;
      if (load) begin
        ena_out   <= take;
        out_bits  <= take ? x_word : '0;
        out_valid <= take ? VAL_W'(x_n) : '0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_stuff_packer.sv
// Bench for jpeg_stuff_packer: bit/byte-queue reference of the packed, stuffed, padded stream
// checked on every output transfer, plus literal word expectations for hand-worked cases.
`timescale 1ns/1ps
module tb_jpeg_stuff_packer;
  localparam int CODE_W = 27;
  localparam int OB     = 2;
  localparam int SIZE_W = $clog2(CODE_W + 1);
  localparam int OUT_W  = 8 * OB;
  localparam int VAL_W  = $clog2(OB + 1);
  localparam int LW     = VAL_W + OUT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CODE_W-1:0] in_code = '0;
  logic [SIZE_W-1:0] in_size = '0;
  logic              ena_in = 1'b0;
  logic              flush = 1'b0;
  logic              rdy_out;
  logic [OUT_W-1:0]  out_bits;
  logic [VAL_W-1:0]  out_valid;
  logic              ena_out;
  logic              rdy_in = 1'b1;
  logic              done_flush;

  jpeg_stuff_packer #(.CODE_W(CODE_W), .OUT_BYTES(OB)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_size(in_size), .ena_in(ena_in),
    .flush(flush), .rdy_out(rdy_out), .out_bits(out_bits), .out_valid(out_valid),
    .ena_out(ena_out), .rdy_in(rdy_in), .done_flush(done_flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && ena_in) assert (int'(in_size) <= CODE_W) else $error("in_size above CODE_W");

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: image bits in order, then the stuffed byte stream the packer must emit.
  bit         bitq[$];
  logic [7:0] byteq[$];
  bit         flushed = 1'b0;
  int         done_cnt = 0;
  logic [LW-1:0] log_q[$];

  function automatic void model_bytes();
    while (bitq.size() >= 8) begin
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
      byteq.push_back(b);
      if (b == 8'hFF) byteq.push_back(8'h00);
    end
  endfunction

  initial begin
    bit         hold_prev;
    logic [LW:0] hold_word;
    hold_prev = 1'b0;
    hold_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bitq.delete();
        byteq.delete();
        flushed   = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) chk("hold_stable", {ena_out, out_valid, out_bits}, hold_word);
        hold_prev = ena_out && !rdy_in;
        hold_word = {ena_out, out_valid, out_bits};
        if (!ena_out) chk("idle_zero", {out_valid, out_bits}, 0);
        if (ena_in && rdy_out) begin
          for (int i = int'(in_size) - 1; i >= 0; i--) bitq.push_back(in_code[i]);
          model_bytes();
        end
        if (flush && rdy_out) begin
          while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
          model_bytes();
          flushed = 1'b1;
        end
        if (ena_out && rdy_in) begin
          int nb;
          int ev;
          logic [OUT_W-1:0] ew;
          ew = '0;
          nb = (byteq.size() < OB) ? byteq.size() : OB;
          ev = flushed ? nb : OB;
          for (int s = 0; s < nb; s++) ew[OUT_W-1-8*s -: 8] = byteq.pop_front();
          chk("word", {out_valid, out_bits}, {VAL_W'(ev), ew});
          log_q.push_back({out_valid, out_bits});
        end
        if (done_flush) begin
          chk("done_empty", {flushed, byteq.size() == 0, bitq.size() == 0}, 3'b111);
          flushed = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  initial forever begin
    @(posedge clk);
    #2;
    rdy_in = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic xfer(input logic [CODE_W-1:0] c, input int sz, input bit dat, input bit fl);
    bit ok;
    int n;
    in_code = c;
    in_size = SIZE_W'(sz);
    ena_in  = dat;
    flush   = fl;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = rdy_out;
      @(posedge clk);
      #1;
      n++;
    end
    ena_in = 1'b0;
    flush  = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: rdy_out 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic send(input logic [CODE_W-1:0] c, input int sz);
    xfer(c, sz, 1'b1, 1'b0);
  endtask

  task automatic do_flush();
    xfer('0, 0, 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("rdy_after_done", rdy_out, 1);
  endtask

  task automatic expect_log(input string nm, input int n, input logic [LW-1:0] e0, e1, e2);
    logic [LW-1:0] e[3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    chk({nm, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) chk(nm, log_q[i], e[i]);
  endtask

  initial begin
    bit saw_low;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rdy_out, ena_out, out_valid, out_bits, done_flush}, 0);
    #2 rst_n = 1'b1;
    chk("rdy_held_low", rdy_out, 0);
    @(posedge clk);
    #1;
    chk("rdy_rises", rdy_out, 1);

    // Four nibbles make one word two cycles after the last is presented.
    log_q.delete();
    repeat (3) send(4'hA, 4);
    send(4'hA, 4);
    chk("t1_not_yet", ena_out, 0);
    @(posedge clk);
    #1;
    chk("t1_latency", {ena_out, out_valid, out_bits}, {1'b1, 2'd2, 16'hAAAA});
    do_flush();
    wait_done();
    expect_log("t1", 1, {2'd2, 16'hAAAA}, '0, '0);

    log_q.delete();
    send(8'hFF, 8); send(8'h12, 8); send(8'h34, 8);
    do_flush();
    wait_done();
    expect_log("t2", 2, {2'd2, 16'hFF00}, {2'd2, 16'h1234}, '0);

    log_q.delete();
    send(8'h12, 8); send(8'hFF, 8); send(8'h34, 8); send(8'h56, 8);
    do_flush();
    wait_done();
    expect_log("t3", 3, {2'd2, 16'h12FF}, {2'd2, 16'h0034}, {2'd1, 16'h5600});

    log_q.delete();
    send(3'b101, 3);
    do_flush();
    wait_done();
    expect_log("t4_pad", 1, {2'd1, 16'hBF00}, '0, '0);

    // Code and flush together: code goes in first, then pads to 0xFF.
    log_q.delete();
    xfer(7'h7F, 7, 1'b1, 1'b1);
    wait_done();
    expect_log("t4_padff", 1, {2'd2, 16'hFF00}, '0, '0);

    rdy_mode = 2;
    @(posedge clk);
    #1;
    saw_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_code = CODE_W'($urandom);
      in_size = SIZE_W'($urandom_range(8, CODE_W));
      ena_in  = 1'b1;
      @(negedge clk);
      if (!rdy_out) saw_low = 1'b1;
      @(posedge clk);
      #1;
    end
    ena_in = 1'b0;
    chk("t5_rdy_fell", saw_low, 1);
    chk("t5_word_held", ena_out, 1);
    rdy_mode = 0;
    do_flush();
    wait_done();

    rdy_mode = 1;
    for (int k = 0; k < 2000; k++) begin
      int sz;
      logic [CODE_W-1:0] c;
      sz = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, CODE_W);
      c  = ($urandom_range(0, 3) == 0) ? {CODE_W{1'b1}} : CODE_W'($urandom);
      if (k % 250 == 249) begin
        if ((k / 250) % 2 == 0) xfer(c, sz, 1'b1, 1'b1);
        else begin
          send(c, sz);
          do_flush();
        end
        wait_done();
      end else begin
        send(c, sz);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end

    // Reset while the drain is stalled on a held word.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(8'h11, 8); send(8'h22, 8); send(8'hFF, 8); send(8'h33, 5);
    do_flush();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_clear", {rdy_out, ena_out, out_valid, out_bits, done_flush}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("t6_rdy_back", rdy_out, 1);
    log_q.delete();
    send(8'h12, 8);
    send(3'b101, 3);
    do_flush();
    wait_done();
    expect_log("t6_clean", 1, {2'd2, 16'h12BF}, '0, '0);
    chk("final_empty", {byteq.size() == 0, bitq.size() == 0}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
